// File: rtl/usb_tx_pkg.sv
// Shared types and timing constants for the USB IN endpoint transmit scheduler.
package usb_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREP,
    ST_SEND,
    ST_WAIT_HS
  } tx_state_e;

  localparam int PREP_CYC    = 3;
  localparam int GUARD_CYC   = 2;
  localparam int MIN_POP_GAP = 2;

endpackage

// File: rtl/usb_tx_flush_timer.sv
// Saturating age counter for a partially filled FIFO; o_expired marks a short
// packet as eligible for transmission.
module usb_tx_flush_timer #(
  parameter int FLUSH_CYC = 4096
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(FLUSH_CYC + 1);
  localparam logic [CW-1:0] LP_LIMIT = CW'(FLUSH_CYC);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt < LP_LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt >= LP_LIMIT);

endmodule

// File: rtl/usb_in_pkt_sched.sv
// Transmit scheduler for one USB IN endpoint: picks full/short/NAK per token,
// sequences the FIFO rewind, byte pops and commit, and retries unacked packets.
module usb_in_pkt_sched
  import usb_tx_pkg::*;
#(
  parameter int ASIZE     = 9,
  parameter int MAX_PKT   = 256,
  parameter int FLUSH_CYC = 4096,
  parameter int ACK_TO    = 1024
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             i_in_tok,
  input  logic             i_hs_ack,
  input  logic             i_hs_abort,
  input  logic             i_tx_pop,
  input  logic [ASIZE:0]   i_fifo_wrnum,
  output logic             o_fifo_read,
  output logic             o_fifo_txact,
  output logic             o_fifo_pktfin,
  output logic             o_tx_start,
  output logic [ASIZE:0]   o_tx_len,
  output logic             o_tx_nak,
  output logic             o_tx_busy,
  output logic             o_err_pop,
  output logic [15:0]      o_pkt_cnt
);

  localparam int AW = $clog2(ACK_TO + 1);
  localparam logic [ASIZE:0] LP_MAX_LEN  = (ASIZE + 1)'(MAX_PKT);
  localparam logic [AW-1:0]  LP_ACK_LAST = AW'(ACK_TO - 1);
  localparam logic [1:0]     LP_PREP_END = 2'(PREP_CYC - 1);
  localparam logic [1:0]     LP_GUARD    = 2'(GUARD_CYC);
  localparam logic [1:0]     LP_GAP      = 2'(MIN_POP_GAP - 1);

  tx_state_e      r_state;
  tx_state_e      w_state_nx;
  logic [1:0]     r_guard;
  logic [1:0]     r_prep_cnt;
  logic [1:0]     r_gap;
  logic [ASIZE:0] r_byte_cnt;
  logic [ASIZE:0] r_tx_len;
  logic [AW-1:0]  r_ack_cnt;
  logic [15:0]    r_pkt_cnt;
  logic           r_txact;
  logic           r_tx_start;
  logic           r_tx_nak;
  logic           r_pktfin;

  logic           w_full;
  logic           w_nonempty;
  logic           w_flush_exp;
  logic           w_pop_ok;
  logic           w_read;
  logic           w_take;
  logic           w_nak;
  logic           w_commit;
  logic           w_to_idle;
  logic [ASIZE:0] w_len;

  // A completely full FIFO (wrnum == 2**ASIZE) still satisfies this compare.
  assign w_full     = (i_fifo_wrnum >= LP_MAX_LEN);
  assign w_nonempty = (i_fifo_wrnum != '0);

  usb_tx_flush_timer #(
    .FLUSH_CYC (FLUSH_CYC)
  ) u_flush_timer (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .i_clear   (!w_nonempty || w_full || w_commit),
    .i_enable  (w_nonempty && !w_full),
    .o_expired (w_flush_exp)
  );

  assign w_pop_ok  = (r_state == ST_SEND) && (r_gap == '0) && (r_byte_cnt != r_tx_len);
  assign w_read    = i_tx_pop && w_pop_ok && !i_hs_abort;
  assign w_to_idle = (w_state_nx == ST_IDLE) && (r_state != ST_IDLE);

  always_comb begin
    w_state_nx = r_state;
    w_take     = 1'b0;
    w_nak      = 1'b0;
    w_commit   = 1'b0;
    w_len      = '0;
    if (i_hs_abort) begin
      w_state_nx = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_in_tok) begin
            if ((r_guard == '0) && w_full) begin
              w_take = 1'b1;
              w_len  = LP_MAX_LEN;
            end else if ((r_guard == '0) && w_nonempty && w_flush_exp) begin
              w_take = 1'b1;
              w_len  = i_fifo_wrnum;
            end else begin
              w_nak = 1'b1;
            end
            if (w_take) begin
              w_state_nx = ST_PREP;
            end
          end
        end
        ST_PREP: begin
          if (r_prep_cnt == LP_PREP_END) begin
            w_state_nx = ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_read && ((r_byte_cnt + 1'b1) == r_tx_len)) begin
            w_state_nx = ST_WAIT_HS;
          end
        end
        ST_WAIT_HS: begin
          // ACK beats a simultaneous retry token; that token is NAKed.
          if (i_hs_ack) begin
            w_commit   = 1'b1;
            w_nak      = i_in_tok;
            w_state_nx = ST_IDLE;
          end else if (i_in_tok || (r_ack_cnt == LP_ACK_LAST)) begin
            w_state_nx = ST_IDLE;
          end
        end
        default: begin
          w_state_nx = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state    <= ST_IDLE;
      r_tx_start <= 1'b0;
      r_tx_nak   <= 1'b0;
      r_pktfin   <= 1'b0;
      r_txact    <= 1'b0;
      r_tx_len   <= '0;
      r_pkt_cnt  <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_tx_start <= (r_state == ST_PREP) && (w_state_nx == ST_SEND);
      r_tx_nak   <= w_nak;
      r_pktfin   <= w_commit;
      if (w_take) begin
        r_txact  <= 1'b1;
        r_tx_len <= w_len;
      end else if (w_to_idle) begin
        r_txact  <= 1'b0;
      end
      if (w_commit) begin
        r_pkt_cnt <= r_pkt_cnt + 1'b1;
      end
    end
  end

  // Guard keeps txact low long enough for the FIFO to see a fresh rise per attempt.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_guard    <= LP_GUARD;
      r_prep_cnt <= '0;
      r_ack_cnt  <= '0;
    end else begin
      if (w_to_idle) begin
        r_guard <= LP_GUARD;
      end else if ((r_state == ST_IDLE) && (r_guard != '0)) begin
        r_guard <= r_guard - 1'b1;
      end
      r_prep_cnt <= (r_state == ST_PREP) ? r_prep_cnt + 1'b1 : '0;
      r_ack_cnt  <= (r_state == ST_WAIT_HS) ? r_ack_cnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_byte_cnt <= '0;
      r_gap      <= '0;
    end else if (w_take) begin
      r_byte_cnt <= '0;
      r_gap      <= '0;
    end else if (w_read) begin
      r_byte_cnt <= r_byte_cnt + 1'b1;
      r_gap      <= LP_GAP;
    end else if (r_gap != '0) begin
      r_gap      <= r_gap - 1'b1;
    end
  end

  assign o_fifo_read   = w_read;
  assign o_err_pop     = i_tx_pop && !w_pop_ok;
  assign o_fifo_txact  = r_txact;
  assign o_fifo_pktfin = r_pktfin;
  assign o_tx_start    = r_tx_start;
  assign o_tx_len      = r_tx_len;
  assign o_tx_nak      = r_tx_nak;
  assign o_tx_busy     = (r_state != ST_IDLE);
  assign o_pkt_cnt     = r_pkt_cnt;

endmodule

// File: tb/tb_usb_in_pkt_sched.sv
// Scoreboard bench for usb_in_pkt_sched: stimulus queues expected output
// events, a negedge monitor pops and compares each event the DUT presents.
module tb_usb_in_pkt_sched;

  localparam int ASIZE = 9;

  logic           CLK;
  logic           RSTn;
  logic           inTok;
  logic           hsAck;
  logic           hsAbort;
  logic           txPop;
  logic [ASIZE:0] wrnum;
  logic           fifoRead;
  logic           fifoTxact;
  logic           fifoPktfin;
  logic           txStart;
  logic [ASIZE:0] txLen;
  logic           txNak;
  logic           txBusy;
  logic           errPop;
  logic [15:0]    pktCnt;

  typedef enum int {EV_RISE, EV_START, EV_FIN, EV_NAK, EV_READ, EV_ERR} evKind_e;
  typedef struct {
    evKind_e kind;
    int      value;
  } expEv_t;

  expEv_t expQ[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     riseCycle = 0;
  int     lowRun = 0;
  logic   prevTxact = 1'b0;

  usb_in_pkt_sched dut (
    .CLK           (CLK),
    .RSTn          (RSTn),
    .i_in_tok      (inTok),
    .i_hs_ack      (hsAck),
    .i_hs_abort    (hsAbort),
    .i_tx_pop      (txPop),
    .i_fifo_wrnum  (wrnum),
    .o_fifo_read   (fifoRead),
    .o_fifo_txact  (fifoTxact),
    .o_fifo_pktfin (fifoPktfin),
    .o_tx_start    (txStart),
    .o_tx_len      (txLen),
    .o_tx_nak      (txNak),
    .o_tx_busy     (txBusy),
    .o_err_pop     (errPop),
    .o_pkt_cnt     (pktCnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pushExp(input evKind_e k, input int v);
    expEv_t e;
    e.kind  = k;
    e.value = v;
    expQ.push_back(e);
  endtask

  task automatic checkEvent(input evKind_e k, input int v);
    expEv_t e;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL event: got %s/%0d, expected nothing queued", k.name(), v);
    end else begin
      e = expQ.pop_front();
      if ((e.kind != k) || (e.value != v)) begin
        errors++;
        $display("[TB] FAIL event: got %s/%0d, expected %s/%0d", k.name(), v, e.kind.name(), e.value);
      end
    end
  endtask

  // Event order per cycle is fixed; same-cycle events must be queued in this order.
  always @(negedge CLK) begin
    if (RSTn) begin
      if (fifoTxact && !prevTxact) begin
        checkEvent(EV_RISE, int'(txLen));
        checkOutput("txact_low_gap_ge2", (lowRun >= 2) ? 1 : 0, 1);
        riseCycle = cyc;
      end
      if (txStart) begin
        checkEvent(EV_START, int'(txLen));
        checkOutput("start_latency", cyc - riseCycle, 3);
      end
      if (fifoPktfin) checkEvent(EV_FIN, int'(pktCnt));
      if (txNak)      checkEvent(EV_NAK, 0);
      if (fifoRead)   checkEvent(EV_READ, 0);
      if (errPop)     checkEvent(EV_ERR, 0);
    end
    lowRun    = fifoTxact ? 0 : lowRun + 1;
    prevTxact = fifoTxact;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input bit tok, input bit ack, input bit abort, input bit pop);
    inTok   = tok;
    hsAck   = ack;
    hsAbort = abort;
    txPop   = pop;
    @(posedge CLK);
    #1;
    inTok   = 1'b0;
    hsAck   = 1'b0;
    hsAbort = 1'b0;
    txPop   = 1'b0;
  endtask

  task automatic waitStart();
    bit seen;
    seen = 1'b0;
    for (int i = 0; (i < 20) && !seen; i++) begin
      @(negedge CLK);
      if (txStart) seen = 1'b1;
    end
    checkOutput("tx_start_seen", int'(seen), 1);
    @(posedge CLK);
    #1;
  endtask

  task automatic sendPops(input int n);
    for (int i = 0; i < n; i++) begin
      pushExp(EV_READ, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      waitCycles(1);
    end
  endtask

  task automatic startPacket(input int len);
    pushExp(EV_RISE, len);
    pushExp(EV_START, len);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    waitStart();
  endtask

  task automatic checkIdleNow(input string tag);
    @(negedge CLK);
    checkOutput({tag, "_busy"}, int'(txBusy), 0);
    checkOutput({tag, "_txact"}, int'(fifoTxact), 0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RSTn    = 1'b0;
    inTok   = 1'b0;
    hsAck   = 1'b0;
    hsAbort = 1'b0;
    txPop   = 1'b0;
    wrnum   = '0;
    repeat (3) @(negedge CLK);
    checkOutput("reset_busy", int'(txBusy), 0);
    checkOutput("reset_txact", int'(fifoTxact), 0);
    checkOutput("reset_pkt_cnt", int'(pktCnt), 0);
    checkOutput("reset_tx_len", int'(txLen), 0);
    checkOutput("reset_pulses", int'({txStart, txNak, fifoPktfin, fifoRead, errPop}), 0);
    @(posedge CLK);
    #1;
    RSTn = 1'b1;
    waitCycles(4);

    // T1 full packet with one back-to-back pop rejected mid-packet
    wrnum = 10'd300;
    startPacket(256);
    sendPops(100);
    pushExp(EV_READ, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    pushExp(EV_ERR, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    waitCycles(1);
    sendPops(155);
    @(negedge CLK);
    checkOutput("t1_wait_hs_busy", int'(txBusy), 1);
    @(posedge CLK);
    #1;
    pushExp(EV_FIN, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    waitCycles(2);
    checkIdleNow("t1_after_ack");
    checkOutput("t1_pkt_cnt", int'(pktCnt), 1);

    // T6 pop while idle
    pushExp(EV_ERR, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    // T2 NAK on empty and on young short data, then flush-expired short packet
    wrnum = 10'd0;
    pushExp(EV_NAK, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    wrnum = 10'd10;
    waitCycles(5);
    pushExp(EV_NAK, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkIdleNow("t2_nak");
    waitCycles(4100);
    startPacket(10);
    sendPops(10);
    pushExp(EV_FIN, 2);
    pushExp(EV_NAK, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    waitCycles(2);
    checkOutput("t2_pkt_cnt", int'(pktCnt), 2);

    // T3 retry token instead of ACK, then the same packet again
    wrnum = 10'd300;
    waitCycles(2);
    startPacket(256);
    sendPops(256);
    waitCycles(3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkIdleNow("t3_retry");
    waitCycles(2);
    startPacket(256);
    sendPops(256);
    pushExp(EV_FIN, 3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    waitCycles(2);
    checkOutput("t3_pkt_cnt", int'(pktCnt), 3);

    // T4 ACK timeout: still busy just before 1024 cycles, idle just after
    wrnum = 10'd10;
    waitCycles(4100);
    startPacket(10);
    sendPops(10);
    waitCycles(1020);
    @(negedge CLK);
    checkOutput("t4_busy_before_to", int'(txBusy), 1);
    @(posedge CLK);
    #1;
    waitCycles(4);
    checkIdleNow("t4_after_to");
    waitCycles(2);
    checkOutput("t4_pkt_cnt_kept", int'(pktCnt), 3);
    startPacket(10);
    sendPops(10);
    pushExp(EV_FIN, 4);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    waitCycles(2);

    // T5 abort mid-packet, then a full FIFO (wrnum = 512) delivers 256 bytes
    wrnum = 10'd300;
    waitCycles(2);
    startPacket(256);
    sendPops(100);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkIdleNow("t5_abort");
    waitCycles(2);
    wrnum = 10'd512;
    startPacket(256);
    sendPops(256);
    pushExp(EV_ERR, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    waitCycles(1);
    pushExp(EV_FIN, 5);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    waitCycles(5);

    @(negedge CLK);
    checkOutput("final_pkt_cnt", int'(pktCnt), 5);
    checkOutput("final_queue_left", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
